// File: rtl/hard_mem_1rw_access_arb.sv
// Single-port SRAM front-end: round-robin merge of read and write requests onto one port,
// with a 2-entry valid/yumi response buffer that captures read data one cycle after issue.
module hard_mem_1rw_access_arb #(
  parameter int width_p       = 64,
  parameter int els_p         = 512,
  parameter int addr_width_lp = $clog2(els_p),
  parameter int mask_width_lp = width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  output logic                     w_ready_o,

  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_ready_o,

  output logic                     r_v_o,
  output logic [width_p-1:0]       r_data_o,
  input  logic                     r_yumi_i,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [mask_width_lp-1:0] mem_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  logic [1:0]         count_q, count_d;
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic               inflight_q, inflight_d;
  logic               last_q, last_d;
  logic [width_p-1:0] buf_q [2];
  logic [width_p-1:0] buf_d [2];

  logic       pop;
  logic       push;
  logic [2:0] occupancy;
  logic       rd_ok;
  logic       grant_w;
  logic       grant_r;

  // A read is only admitted if its response is guaranteed a buffer slot.
  always_comb begin
    pop       = r_yumi_i & (count_q != 2'd0);
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_ok     = (occupancy < 3'd2);

    grant_w = 1'b0;
    grant_r = 1'b0;
    if (!reset_i) begin
      if (w_v_i && r_v_i && rd_ok) begin
        grant_r = ~last_q;
        grant_w = last_q;
      end else if (w_v_i) begin
        grant_w = 1'b1;
      end else if (r_v_i && rd_ok) begin
        grant_r = 1'b1;
      end
    end
  end

  always_comb begin
    w_ready_o  = grant_w;
    r_ready_o  = grant_r;
    mem_v_o    = grant_w | grant_r;
    mem_w_o    = grant_w;
    mem_addr_o = grant_w ? w_addr_i : r_addr_i;
    mem_data_o = w_data_i;
    mem_mask_o = grant_w ? w_mask_i : '0;

    r_v_o    = (count_q != 2'd0);
    r_data_o = buf_q[head_q];
  end

  always_comb begin
    last_d     = last_q;
    if (grant_w) last_d = 1'b0;
    else if (grant_r) last_d = 1'b1;

    inflight_d = grant_r;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ push;

    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (push) buf_d[tail_q] = mem_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
    end
  end

  // Response storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    buf_q[0] <= buf_d[0];
    buf_q[1] <= buf_d[1];
  end

endmodule

// File: tb/tb_hard_mem_1rw_access_arb.sv
// Directed bench for hard_mem_1rw_access_arb with a behavioural byte-masked SRAM behind it.
module tb_hard_mem_1rw_access_arb;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        w_v_i;
  logic [8:0]  w_addr_i;
  logic [63:0] w_data_i;
  logic [7:0]  w_mask_i;
  logic        w_ready_o;
  logic        r_v_i;
  logic [8:0]  r_addr_i;
  logic        r_ready_o;
  logic        r_v_o;
  logic [63:0] r_data_o;
  logic        r_yumi_i;
  logic        mem_v_o;
  logic        mem_w_o;
  logic [8:0]  mem_addr_o;
  logic [63:0] mem_data_o;
  logic [7:0]  mem_mask_o;
  logic [63:0] mem_data_i;

  int checkCount = 0;
  int errorCount = 0;

  hard_mem_1rw_access_arb dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .w_v_i      (w_v_i),
    .w_addr_i   (w_addr_i),
    .w_data_i   (w_data_i),
    .w_mask_i   (w_mask_i),
    .w_ready_o  (w_ready_o),
    .r_v_i      (r_v_i),
    .r_addr_i   (r_addr_i),
    .r_ready_o  (r_ready_o),
    .r_v_o      (r_v_o),
    .r_data_o   (r_data_o),
    .r_yumi_i   (r_yumi_i),
    .mem_v_o    (mem_v_o),
    .mem_w_o    (mem_w_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_mask_o (mem_mask_o),
    .mem_data_i (mem_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pattern(input int a);
    return {16'hC0DE, a[15:0], 16'hF00D, a[15:0]};
  endfunction

  function automatic logic [63:0] expData(input int a);
    return (a == 5) ? 64'hDEADBEEF_FFFFFFFF : pattern(a);
  endfunction

  // Behavioural SRAM: output is garbage except in the cycle after a read strobe.
  logic [63:0] mem [512];
  logic [63:0] rdQ;
  logic        rdValid = 1'b0;
  bit          memInit;

  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 512; i++) mem[i] <= pattern(i);
      memInit <= 1'b1;
      rdValid <= 1'b0;
    end else begin
      rdValid <= mem_v_o & ~mem_w_o;
      if (mem_v_o && mem_w_o) begin
        for (int b = 0; b < 8; b++)
          if (mem_mask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else if (mem_v_o) begin
        rdQ <= mem[mem_addr_o];
      end
    end
  end

  assign mem_data_i = rdValid ? rdQ : 64'hBADBADBA_DBADBAD0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [8:0] wa, input logic [63:0] wd,
                               input logic [7:0] wm, input logic rv, input logic [8:0] ra,
                               input logic yumi);
    w_v_i    = wv;
    w_addr_i = wa;
    w_data_i = wd;
    w_mask_i = wm;
    r_v_i    = rv;
    r_addr_i = ra;
    r_yumi_i = yumi;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, r_v_o);
      nextCycle();
    end
  endtask

  // The response buffer must never claim more than two entries.
  always @(negedge clk) begin
    if (reset_i === 1'b0) checkOutput("countBound", 64'(dut.count_q <= 2'd2), 64'd1);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    applyStimulus(1'b1, 9'd3, 64'h1, 8'hFF, 1'b1, 9'd4, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("rstWReady", 64'(w_ready_o), 64'd0);
    checkOutput("rstRReady", 64'(r_ready_o), 64'd0);
    checkOutput("rstMemV", 64'(mem_v_o), 64'd0);
    checkOutput("rstRV", 64'(r_v_o), 64'd0);
    nextCycle();
    reset_i = 1'b0;

    // Full-mask write then read-back of the same address.
    applyStimulus(1'b1, 9'd5, 64'hDEADBEEF_01234567, 8'hFF, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("wrReady", 64'(w_ready_o), 64'd1);
    checkOutput("wrMemV", 64'(mem_v_o), 64'd1);
    checkOutput("wrMemW", 64'(mem_w_o), 64'd1);
    checkOutput("wrMemAddr", 64'(mem_addr_o), 64'd5);
    checkOutput("wrMemData", mem_data_o, 64'hDEADBEEF_01234567);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd5, 1'b0);
    @(negedge clk);
    checkOutput("rdReady", 64'(r_ready_o), 64'd1);
    checkOutput("rdMemW", 64'(mem_w_o), 64'd0);
    checkOutput("rdMemMask", 64'(mem_mask_o), 64'd0);
    checkOutput("rdMemAddr", 64'(mem_addr_o), 64'd5);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("rdLatency1", 64'(r_v_o), 64'd0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("rdRespV", 64'(r_v_o), 64'd1);
    checkOutput("rdRespData", r_data_o, 64'hDEADBEEF_01234567);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("rdRespPopped", 64'(r_v_o), 64'd0);
    nextCycle();

    // Partial-mask overwrite: only the low four bytes change.
    applyStimulus(1'b1, 9'd5, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 1'b0, '0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd5, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("maskRespV", 64'(r_v_o), 64'd1);
    checkOutput("maskRespData", r_data_o, 64'hDEADBEEF_FFFFFFFF);
    nextCycle();

    // Contention from a fresh reset alternates, starting with the write.
    reset_i = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    nextCycle();
    reset_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 9'(20 + k), 64'(k), 8'hFF, 1'b1, 9'd5, r_v_o);
      @(negedge clk);
      checkOutput($sformatf("rrWReady%0d", k), 64'(w_ready_o), 64'(k % 2 == 0));
      checkOutput($sformatf("rrRReady%0d", k), 64'(r_ready_o), 64'(k % 2 == 1));
      checkOutput($sformatf("rrAddr%0d", k), 64'(mem_addr_o), (k % 2 == 0) ? 64'(20 + k) : 64'd5);
      checkOutput($sformatf("rrRespV%0d", k), 64'(r_v_o), 64'(k == 3 || k == 5));
      if (k == 3 || k == 5) checkOutput($sformatf("rrRespData%0d", k), r_data_o, 64'hDEADBEEF_FFFFFFFF);
      nextCycle();
    end
    drain(4);

    // Backpressure: two reads admitted, third refused, writes still pass.
    for (int c = 0; c < 7; c++) begin
      logic wv, rv, yumi;
      wv   = (c == 3);
      rv   = (c < 5);
      yumi = (c >= 4);
      applyStimulus(wv, 9'd100, 64'h55, 8'hFF, rv, 9'(c), yumi);
      @(negedge clk);
      if (c < 5) checkOutput($sformatf("stallRReady%0d", c), 64'(r_ready_o), 64'(c < 2 || c == 4));
      if (c == 3) checkOutput("stallWReady", 64'(w_ready_o), 64'd1);
      if (c == 4) checkOutput("stallHead0", r_data_o, expData(0));
      if (c == 5) checkOutput("stallHead1", r_data_o, expData(1));
      if (c == 6) checkOutput("stallHead4", r_data_o, expData(4));
      nextCycle();
    end
    drain(4);

    // Back-to-back reads with the consumer always taking the head.
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b0, '0, '0, '0, (c < 8), 9'(c), r_v_o);
      @(negedge clk);
      if (c < 8) checkOutput($sformatf("b2bRReady%0d", c), 64'(r_ready_o), 64'd1);
      checkOutput($sformatf("b2bRespV%0d", c), 64'(r_v_o), 64'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) checkOutput($sformatf("b2bData%0d", c), r_data_o, expData(c - 2));
      nextCycle();
    end
    drain(2);

    // Asynchronous reset with one entry buffered and one read in flight.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("preRstRV", 64'(r_v_o), 64'd1);
    reset_i = 1'b1;
    #1;
    checkOutput("midRstRV", 64'(r_v_o), 64'd0);
    applyStimulus(1'b1, 9'd7, 64'h77, 8'hFF, 1'b1, 9'd3, 1'b0);
    #1;
    checkOutput("midRstWReady", 64'(w_ready_o), 64'd0);
    checkOutput("midRstRReady", 64'(r_ready_o), 64'd0);
    checkOutput("midRstMemV", 64'(mem_v_o), 64'd0);
    nextCycle();
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("noStale%0d", c), 64'(r_v_o), 64'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 9'd200, 64'h99, 8'hFF, 1'b1, 9'd6, 1'b0);
    @(negedge clk);
    checkOutput("postRstWFirst", 64'(w_ready_o), 64'd1);
    checkOutput("postRstRHeld", 64'(r_ready_o), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("postRstRSecond", 64'(r_ready_o), 64'd1);
    checkOutput("postRstWHeld", 64'(w_ready_o), 64'd0);
    nextCycle();
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hard_mem_1rw_access_arb.md
# hard_mem_1rw_access_arb

Front-end for a single-ported, byte-masked synchronous SRAM (default 512x64, read data valid one cycle after a read strobe and undefined otherwise). Merges independent read and write request streams onto the one port with round-robin arbitration and holds returned read data in a 2-entry response buffer with valid/yumi handshake. With this block in front of the hardened memory, consumers never sample raw SRAM output and can apply backpressure without losing read data.

## Interface
- width_p, 64, data width; must be a multiple of 8
- els_p, 512, memory depth
- addr_width_lp, $clog2(els_p), address width
- mask_width_lp, width_p>>3, byte-enable width
- clk_i  in  1  clock; all state updates on the posedge
- reset_i  in  1  reset; asynchronous and active-high
- w_v_i  in  1  write request valid
- w_addr_i  in  addr_width_lp  write address
- w_data_i  in  width_p  write data
- w_mask_i  in  mask_width_lp  byte enables; bit i covers data bits [8i+7:8i]
- w_ready_o  out  1  write accepted this cycle; posted, no acknowledge
- r_v_i  in  1  read request valid
- r_addr_i  in  addr_width_lp  read address
- r_ready_o  out  1  read accepted this cycle
- r_v_o  out  1  read response valid (head of the response buffer)
- r_data_o  out  width_p  read response data
- r_yumi_i  in  1  consumer takes the head this cycle; legal only when r_v_o=1
- mem_v_o  out  1  SRAM strobe
- mem_w_o  out  1  SRAM write enable
- mem_addr_o  out  addr_width_lp  SRAM address
- mem_data_o  out  width_p  SRAM write data
- mem_mask_o  out  mask_width_lp  SRAM byte mask
- mem_data_i  in  width_p  SRAM read data; valid only in the cycle after a read strobe

## Operation
- State: `inflight_r` (read issued last cycle), response buffer of 2 entries with `count_r` (0..2), head/tail pointers, and `last_r` (last grant; 0=write, 1=read).
- Read eligibility: `rd_ok = (count_r + inflight_r - r_yumi_i) < 2`. r_ready_o depends combinationally on r_yumi_i and r_v_i.
- Grant:
  - Write only requesting: grant write.
  - Read only requesting and rd_ok: grant read.
  - Both requesting and rd_ok: grant the opposite of `last_r`.
  - Both requesting and !rd_ok: grant write.
  - `last_r` updates only on a grant.
- Ready outputs depend combinationally on the corresponding valid. Requesters must not make a valid depend on a ready.
- Write grant: w_ready_o=1, mem_v_o=1, mem_w_o=1, mem_addr_o=w_addr_i, mem_data_o=w_data_i, mem_mask_o=w_mask_i.
- Read grant: r_ready_o=1, mem_v_o=1, mem_w_o=0, mem_addr_o=r_addr_i, mem_mask_o=0.
- No grant: mem_v_o=0; the other SRAM outputs are don't-care.
- `inflight_r <= read granted`. When `inflight_r=1`, mem_data_i is written into the buffer tail at the end of that cycle.
- Buffer: r_v_o = (count_r != 0); r_data_o = entry at head.
  - r_yumi_i advances head.
  - Push and pop in the same cycle leave count_r unchanged.
  - Push and pop with count_r=1 are legal.
- Overflow is impossible by construction. The bench asserts count_r never exceeds 2.
- No address-hazard logic is needed: the single port serialises accesses. A read granted after a write to the same address returns the new data.
- Reset (asynchronous, any time): count_r=0, pointers=0, inflight_r=0, last_r=1 so the first contended grant goes to write. Any in-flight read is discarded. While reset_i=1, all ready outputs and mem_v_o are 0.
- Output values while in reset: r_v_o=0, w_ready_o=0, r_ready_o=0, mem_v_o=0. r_data_o and the other mem_* outputs are don't-care; buffer storage is not reset.

## Timing
- Request path is combinational: accept in cycle N drives the SRAM in cycle N.
- Read latency is 2: accepted in N, mem_data_i valid in N+1, r_v_o=1 in N+2 (earliest).
- Throughput: one access per cycle. Back-to-back reads with r_yumi_i held high sustain 1 read/cycle.
- With r_yumi_i=0, at most 2 reads are outstanding or buffered. A third read is refused until a yumi.

## Test plan
- Write 0xDEADBEEF_01234567 to addr 5 with mask 0xFF, then read addr 5 -> r_v_o rises 2 cycles after read accept with that data.
- Write mask 0x0F with data 0xFFFFFFFF_FFFFFFFF over addr 5 holding 0xDEADBEEF_01234567, then read -> 0xDEADBEEF_FFFFFFFF.
- w_v_i and r_v_i held high for 6 cycles, buffer drained each cycle -> grants alternate W,R,W,R,W,R starting with write after reset.
- r_yumi_i=0, r_v_i held high -> exactly 2 reads accepted, then r_ready_o=0.
  - Writes are still granted during the stall.
  - Raising r_yumi_i re-enables reads in the same cycle.
- 8 back-to-back reads of addrs 0..7 with r_yumi_i=1 -> 8 responses in 8 consecutive cycles, in order, no bubble.
- Assert reset_i asynchronously mid-cycle with one read in flight and 1 entry buffered:
  - r_v_o drops immediately.
  - After release, no stale response appears and the first contended grant is write.
